// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel edge-magnitude stream.
package sobel_pkg;
   localparam int PIX_W = 8;
   localparam int MAG_W = 12;

   typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

   // (R + 2G + B) / 4 with a 10-bit sum, truncated back to a pixel
   function automatic logic [PIX_W-1:0] rgb2gray(input logic [PIX_W-1:0] r,
                                                 input logic [PIX_W-1:0] g,
                                                 input logic [PIX_W-1:0] b);
      logic [9:0] sum;
      sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
      return sum[9:2];
   endfunction
endpackage

// File: rtl/sobel_line_buf.sv
// Two cascaded IMG_W-deep gray delays: tap1 is the pixel one line back, tap2 two lines back.
module sobel_line_buf import sobel_pkg::*; #(
   parameter int IMG_W = 128
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             shift_en,
   input  logic [PIX_W-1:0] din,
   output logic [PIX_W-1:0] tap1,
   output logic [PIX_W-1:0] tap2
);
   localparam int AW = $clog2(IMG_W);

   logic [PIX_W-1:0] line1 [IMG_W];
   logic [PIX_W-1:0] line2 [IMG_W];
   logic [AW-1:0]    ptr;

   // circular buffer: the slot about to be overwritten holds the pixel from IMG_W shifts ago
   assign tap1 = line1[ptr];
   assign tap2 = line2[ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          ptr <= '0;
      else if (shift_en) ptr <= (ptr == AW'(IMG_W - 1)) ? '0 : ptr + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (shift_en) begin
         line1[ptr] <= din;
         line2[ptr] <= line1[ptr];
      end
   end
endmodule

// File: rtl/sobel_stream.sv
// Streaming RGB -> gray -> 3x3 Sobel |Gx|+|Gy| with border zeroing and 3-cycle output latency.
// Define SOBEL_THRESH_EN to add thresh_i and emit a binary 0/255 edge map instead of the magnitude.
module sobel_stream import sobel_pkg::*; #(
   parameter int IMG_W = 128,
   parameter int IMG_H = 128
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PIX_W-1:0] cam_red_i,
   input  logic [PIX_W-1:0] cam_green_i,
   input  logic [PIX_W-1:0] cam_blue_i,
   input  logic             cam_done_i,
   input  logic             cam_sof_i,
`ifdef SOBEL_THRESH_EN
   input  logic [PIX_W-1:0] thresh_i,
`endif
   output logic [PIX_W-1:0] sobel_red_o,
   output logic [PIX_W-1:0] sobel_green_o,
   output logic [PIX_W-1:0] sobel_blue_o,
   output logic             sobel_done_o,
   output logic             busy_o
);
   localparam int CW     = $clog2(IMG_W);
   localparam int RW     = $clog2(IMG_H);
   localparam int FW     = $clog2(IMG_W + 1);
   localparam int STAGES = 3;

   state_t            state, state_nx;
   logic [CW-1:0]     col, cur_col, col_inc, ocol;
   logic [RW-1:0]     row, cur_row, row_inc, orow;
   logic [FW-1:0]     fcnt;
   logic              acc, start, take, shift, emit, border;
   logic [PIX_W-1:0]  din, tap1, tap2;

   always_comb begin
      acc     = cam_done_i && (state != FLUSH);
      start   = acc && cam_sof_i;
      take    = start || (acc && state != IDLE);
      shift   = take || (state == FLUSH);
      emit    = (state == RUN && acc && !start) || (state == FLUSH);
      din     = (state == FLUSH) ? '0 : rgb2gray(cam_red_i, cam_green_i, cam_blue_i);
      cur_col = start ? '0 : col;
      cur_row = start ? '0 : row;
      col_inc = (cur_col == CW'(IMG_W - 1)) ? '0 : cur_col + 1'b1;
      row_inc = (cur_col != CW'(IMG_W - 1)) ? cur_row :
                (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + 1'b1;
      border  = (orow == '0) || (orow == RW'(IMG_H - 1)) ||
                (ocol == '0) || (ocol == CW'(IMG_W - 1));
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (start) state_nx = FILL;
         FILL:  if (start) state_nx = FILL;
                else if (acc && cur_row == RW'(1) && cur_col == '0) state_nx = RUN;
         RUN:   if (start) state_nx = FILL;
                else if (acc && cur_row == RW'(IMG_H - 1) && cur_col == CW'(IMG_W - 1))
                   state_nx = FLUSH;
         FLUSH: if (fcnt == FW'(IMG_W)) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         col   <= '0;
         row   <= '0;
         ocol  <= '0;
         orow  <= '0;
         fcnt  <= '0;
      end else begin
         state <= state_nx;
         fcnt  <= (state == FLUSH) ? fcnt + 1'b1 : '0;
         if (take) begin
            col <= col_inc;
            row <= row_inc;
         end
         // output coordinates trail the input by IMG_W+1 and drive the border test
         if (start) begin
            ocol <= '0;
            orow <= '0;
         end else if (emit) begin
            ocol <= (ocol == CW'(IMG_W - 1)) ? '0 : ocol + 1'b1;
            if (ocol == CW'(IMG_W - 1))
               orow <= (orow == RW'(IMG_H - 1)) ? '0 : orow + 1'b1;
         end
      end
   end

   sobel_line_buf #(.IMG_W(IMG_W)) u_line_buf (
      .clk      (clk),
      .rst      (rst),
      .shift_en (shift),
      .din      (din),
      .tap1     (tap1),
      .tap2     (tap2)
   );

   // win[row][col]: row 0 is two lines back, col 2 is the newest column
   logic [2:0][2:0][PIX_W-1:0] win;
   logic [9:0]                 gx_p, gx_n, gy_p, gy_n;
   logic signed [10:0]         gx_q, gy_q;
   logic [10:0]                ax, ay;
   logic [MAG_W-1:0]           mag_q;
   logic [PIX_W-1:0]           res, mag_out;
   logic [STAGES:0]            vld_pipe;
   logic [STAGES-1:0]          bd_pipe;

   always_ff @(posedge clk) begin
      if (shift) begin
         for (int r = 0; r < 3; r++) begin
            win[r][0] <= win[r][1];
            win[r][1] <= win[r][2];
         end
         win[0][2] <= tap2;
         win[1][2] <= tap1;
         win[2][2] <= din;
      end
   end

   always_comb begin
      gx_p = {2'b00, win[0][2]} + {1'b0, win[1][2], 1'b0} + {2'b00, win[2][2]};
      gx_n = {2'b00, win[0][0]} + {1'b0, win[1][0], 1'b0} + {2'b00, win[2][0]};
      gy_p = {2'b00, win[2][0]} + {1'b0, win[2][1], 1'b0} + {2'b00, win[2][2]};
      gy_n = {2'b00, win[0][0]} + {1'b0, win[0][1], 1'b0} + {2'b00, win[0][2]};
      ax   = gx_q[10] ? 11'(-gx_q) : 11'(gx_q);
      ay   = gy_q[10] ? 11'(-gy_q) : 11'(gy_q);
`ifdef SOBEL_THRESH_EN
      res  = (mag_q >= {4'b0000, thresh_i}) ? 8'hFF : 8'h00;
`else
      res  = (mag_q > 12'd255) ? 8'hFF : mag_q[PIX_W-1:0];
`endif
   end

   always_ff @(posedge clk) begin
      gx_q  <= $signed({1'b0, gx_p}) - $signed({1'b0, gx_n});
      gy_q  <= $signed({1'b0, gy_p}) - $signed({1'b0, gy_n});
      mag_q <= {1'b0, ax} + {1'b0, ay};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_pipe <= '0;
         bd_pipe  <= '0;
         mag_out  <= '0;
      end else begin
         vld_pipe <= {vld_pipe[STAGES-1:0], emit};
         bd_pipe  <= {bd_pipe[STAGES-2:0], border};
         if (vld_pipe[STAGES-1]) mag_out <= bd_pipe[STAGES-1] ? '0 : res;
      end
   end

   assign sobel_red_o   = mag_out;
   assign sobel_green_o = mag_out;
   assign sobel_blue_o  = mag_out;
   assign sobel_done_o  = vld_pipe[STAGES];
   assign busy_o        = (state == FLUSH);
endmodule

// File: tb/tb_sobel_stream.sv
// Self-checking bench for sobel_stream: frame-level image model plus literal frame checks.
module tb_sobel_stream;
   localparam int W = 16;
   localparam int H = 8;
   localparam int N = W * H;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] cam_red_i = '0, cam_green_i = '0, cam_blue_i = '0;
   logic       cam_done_i = 1'b0, cam_sof_i = 1'b0;
   logic [7:0] sobel_red_o, sobel_green_o, sobel_blue_o;
   logic       sobel_done_o, busy_o;
`ifdef SOBEL_THRESH_EN
   logic [7:0] thresh_i = 8'd100;
`endif

   sobel_stream #(.IMG_W(W), .IMG_H(H)) dut (
      .clk           (clk),
      .rst           (rst),
      .cam_red_i     (cam_red_i),
      .cam_green_i   (cam_green_i),
      .cam_blue_i    (cam_blue_i),
      .cam_done_i    (cam_done_i),
      .cam_sof_i     (cam_sof_i),
`ifdef SOBEL_THRESH_EN
      .thresh_i      (thresh_i),
`endif
      .sobel_red_o   (sobel_red_o),
      .sobel_green_o (sobel_green_o),
      .sobel_blue_o  (sobel_blue_o),
      .sobel_done_o  (sobel_done_o),
      .busy_o        (busy_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model: whole-frame gray image ----------------
   typedef struct {int due; int val;} exp_t;
   exp_t exp_q[$];
   int   img[N];
   int   m_n = 0, m_fk = 0, m_acc17 = -1;
   bit   m_active = 0, m_flush = 0;

   function automatic int gray_of(input int r, input int g, input int b);
      return (r + 2 * g + b) / 4;
   endfunction

   function automatic int px(input int r, input int c);
      return img[r * W + c];
   endfunction

   function automatic int expect_px(input int p);
      int r, c, gx, gy, mag;
      r = p / W;
      c = p % W;
      if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 0;
      gx = (px(r-1,c+1) + 2*px(r,c+1) + px(r+1,c+1)) - (px(r-1,c-1) + 2*px(r,c-1) + px(r+1,c-1));
      gy = (px(r+1,c-1) + 2*px(r+1,c) + px(r+1,c+1)) - (px(r-1,c-1) + 2*px(r-1,c) + px(r-1,c+1));
      mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_THRESH_EN
      return (mag >= int'(thresh_i)) ? 255 : 0;
`else
      return (mag > 255) ? 255 : mag;
`endif
   endfunction

   always @(posedge clk) begin
      cyc++;
      if (!rst) begin
         m_active = 0;
         m_flush  = 0;
      end else if (m_flush) begin
         exp_q.push_back('{cyc + 3, expect_px(N - W - 1 + m_fk)});
         m_fk++;
         if (m_fk == W + 1) m_flush = 0;
      end else if (cam_done_i && (cam_sof_i || m_active)) begin
         if (cam_sof_i) begin
            m_n = 0;
            m_active = 1;
         end
         img[m_n] = gray_of(int'(cam_red_i), int'(cam_green_i), int'(cam_blue_i));
         if (m_n == W + 1) m_acc17 = cyc;
         if (m_n >= W + 1) exp_q.push_back('{cyc + 3, expect_px(m_n - W - 1)});
         if (m_n == N - 1) begin
            m_active = 0;
            m_flush  = 1;
            m_fk     = 0;
         end else begin
            m_n++;
         end
      end
   end

   // ---------------- per-cycle compare, away from the active edge ----------------
   int         outs[$];
   int         first_cyc = -1;
   int         bcnt = 0;
   logic [7:0] last_out = '0;

   always @(negedge clk) begin
      if (!rst) begin
         chk("rst_out", int'(sobel_red_o), 0);
         chk("rst_done", int'(sobel_done_o), 0);
         chk("rst_busy", int'(busy_o), 0);
         exp_q.delete();
      end else begin
         bit   due_now;
         exp_t e;
         while (exp_q.size() > 0 && exp_q[0].due < cyc) void'(exp_q.pop_front());
         due_now = (exp_q.size() > 0 && exp_q[0].due == cyc);
         chk("busy", int'(busy_o), int'(m_flush));
         chk("valid", int'(sobel_done_o), int'(due_now));
         if (busy_o) bcnt++;
         if (due_now) begin
            e = exp_q.pop_front();
            if (sobel_done_o) chk("pixel", int'(sobel_red_o), e.val);
         end
         if (sobel_done_o) begin
            outs.push_back(int'(sobel_red_o));
            if (outs.size() == 1) first_cyc = cyc;
         end else begin
            chk("hold", int'(sobel_red_o), int'(last_out));
         end
         chk("green_eq", int'(sobel_green_o), int'(sobel_red_o));
         chk("blue_eq", int'(sobel_blue_o), int'(sobel_red_o));
      end
      last_out = sobel_red_o;
   end

   // ---------------- stimulus ----------------
   task automatic drive_pix(input int kind, input int idx, input bit sof, input int gap_pct);
      int   c;
      logic [7:0] v;
      c = idx % W;
      while (int'($urandom_range(99)) < gap_pct) begin
         cam_done_i  = 1'b0;
         cam_sof_i   = 1'b0;
         cam_red_i   = 8'($urandom);
         @(negedge clk);
      end
      case (kind)
         0: begin cam_red_i = 8'h80; cam_green_i = 8'h80; cam_blue_i = 8'h80; end
         1: begin
            v = (c < 8) ? 8'h00 : 8'hFF;
            cam_red_i = v; cam_green_i = v; cam_blue_i = v;
         end
         default: begin
            cam_red_i = 8'($urandom); cam_green_i = 8'($urandom); cam_blue_i = 8'($urandom);
         end
      endcase
      cam_done_i = 1'b1;
      cam_sof_i  = sof;
      @(negedge clk);
      cam_done_i = 1'b0;
      cam_sof_i  = 1'b0;
   endtask

   task automatic run_frame(input int kind, input int gap_pct);
      for (int i = 0; i < N; i++) drive_pix(kind, i, i == 0, gap_pct);
   endtask

   task automatic drain();
      repeat (W + 12) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
   endtask

   // kind 0: uniform frame, kind 1: black/white split at column 8
   task automatic check_literal(input int kind);
      int r, c, ev;
      chk("lit_count", outs.size(), N);
      for (int i = 0; i < outs.size() && i < N; i++) begin
         r  = i / W;
         c  = i % W;
         ev = (kind == 1 && r >= 1 && r <= H - 2 && (c == 7 || c == 8)) ? 255 : 0;
         chk(kind == 1 ? "edge_lit" : "uniform_lit", outs[i], ev);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_out", int'(sobel_red_o), 0);
      chk("reset_done", int'(sobel_done_o), 0);
      chk("reset_busy", int'(busy_o), 0);
      #2 rst = 1'b1;
      @(negedge clk);

      // pixels with no sof while idle must be dropped
      for (int i = 0; i < 5; i++) drive_pix(2, i, 1'b0, 0);
      repeat (6) @(negedge clk);
      chk("idle_discard", outs.size(), 0);

      outs.delete();
      run_frame(0, 0);
      drain();
      check_literal(0);

      outs.delete();
      run_frame(1, 0);
      drain();
      check_literal(1);

      outs.delete();
      bcnt = 0;
      m_acc17 = -1;
      run_frame(2, 50);
      drain();
      chk("rand_count", outs.size(), N);
      chk("first_latency", first_cyc, m_acc17 + 3);
      chk("busy_cycles", bcnt, W + 1);

      // reset in the middle of a frame
      for (int i = 0; i < 40; i++) drive_pix(2, i, i == 0, 0);
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      outs.delete();
      run_frame(2, 25);
      drain();
      chk("after_reset_count", outs.size(), N);

      // restart a frame with sof at pixel 60
      for (int i = 0; i < 60; i++) drive_pix(2, i, i == 0, 0);
      repeat (5) @(negedge clk);
      outs.delete();
      run_frame(2, 0);
      drain();
      chk("restart_count", outs.size(), N);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/sobel_stream.md
SOBEL_STREAM -- requirements
Module: sobel_stream

Interface
REQ-001 SHALL have parameter IMG_W, default 128: pixels per line, at least 4 and a multiple of 4.
REQ-002 SHALL have parameter IMG_H, default 128: lines per frame, at least 3.
REQ-003 SHALL have port clk, input, 1: single clock; all logic rising-edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports cam_red_i, cam_green_i and cam_blue_i, each input, 8: pixel components, sampled when cam_done_i=1.
REQ-006 SHALL have port cam_done_i, input, 1: input pixel valid, one pixel per high cycle, raster order.
REQ-007 SHALL have port cam_sof_i, input, 1: start of frame, qualified by cam_done_i, marking pixel (0,0).
REQ-008 SHALL have ports sobel_red_o, sobel_green_o and sobel_blue_o, each output, 8: edge magnitude, same value on all three.
REQ-009 SHALL have port sobel_done_o, output, 1: output pixel valid.
REQ-010 SHALL have port busy_o, output, 1: high during FLUSH; input is ignored while high.

Function
REQ-011 SHALL compute gray = (R + 2G + B) >> 2 in 10-bit intermediate width, truncated to 8 bits.
REQ-012 SHALL keep two IMG_W-deep gray line buffers plus a 3x3 window, advancing only on accepted pixels; gaps in cam_done_i stall without loss.
REQ-013 SHALL compute Gx and Gy with the standard Sobel kernels in 11-bit signed arithmetic, sum |Gx|+|Gy| in 12 bits unsigned, and saturate the result to 255.
REQ-014 SHALL output 0 for border pixels (row 0, row IMG_H-1, column 0, column IMG_W-1).
REQ-015 SHALL emit output pixel p exactly 3 cycles after acceptance of input pixel p+IMG_W+1, or after the corresponding flush cycle.
REQ-016 SHALL emit exactly IMG_W*IMG_H output pixels per frame, in raster order.
REQ-017 SHALL implement states IDLE, FILL, RUN and FLUSH.
REQ-018 SHALL go IDLE->FILL on cam_done_i with cam_sof_i.
REQ-019 SHALL go FILL->RUN once IMG_W+1 pixels have been accepted.
REQ-020 SHALL go RUN->FLUSH on acceptance of pixel (IMG_H-1, IMG_W-1).
REQ-021 SHALL, in FLUSH, generate IMG_W+1 internal zero-gray pixels at one per cycle, then return to IDLE.
REQ-022 SHALL discard cam_done_i in IDLE when cam_sof_i=0.
REQ-023 SHALL, on cam_sof_i during FILL or RUN, abandon the current frame without emitting its remaining outputs, clear the counters, and restart FILL with that pixel as (0,0).
REQ-024 SHALL wrap the column counter at IMG_W-1 and the row counter at IMG_H-1.
REQ-025 SHALL hold sobel_*_o stable while sobel_done_o=0.

Reset
REQ-026 SHALL, on rst low, asynchronously set: state IDLE; counters 0; sobel_*_o 0; sobel_done_o 0; busy_o 0; pipeline valid bits 0.
REQ-027 SHALL NOT reset line buffer contents; the border rule and FILL gating make them don't-care.
REQ-028 SHALL produce no output pulse for a frame interrupted by reset; the first frame after reset begins at the next cam_sof_i.

Configuration
REQ-029 SHALL, with SOBEL_THRESH_EN defined, add port thresh_i (input, 8) and output 255 when magnitude >= thresh_i, else 0; border pixels remain 0.
REQ-030 SHALL, without SOBEL_THRESH_EN, omit thresh_i and output the saturated magnitude.

Structure
REQ-031 SHALL place the state enum, the PIX_W=8 and MAG_W=12 constants, and the gray conversion function in package sobel_pkg.
REQ-032 SHALL implement the two-line gray delay as sub-module sobel_line_buf, parametrised on IMG_W, with a shift-enable input.

Verification
REQ-033 SHALL test a uniform 16x8 frame (all RGB = 0x80) -> 128 outputs, all 0.
REQ-034 SHALL test a 16x8 frame with a vertical edge (columns 0-7 black, 8-15 white) -> columns 7 and 8 of rows 1-6 = 255, all others 0.
REQ-035 SHALL test a 16x8 frame with random pixels and cam_done_i 50% duty -> output matches the software model; per REQ-015, first sobel_done_o is 3 cycles after acceptance of pixel 17; busy_o high for exactly 17 cycles.
REQ-036 SHALL test rst low mid-frame at pixel 40, then a new frame -> outputs 0 during reset, then a full correct 128-pixel frame.
REQ-037 SHALL test cam_sof_i reasserted at pixel 60 -> the old frame is abandoned and the new frame produces exactly 128 outputs.
REQ-038 SHALL test, with SOBEL_THRESH_EN and thresh_i=100, the edge frame -> edge pixels 255, all others 0.
